// File: rtl/rec_play_ctrl.sv
// Recorder transport controller: button-driven record/play/pause FSM that paces SRAM
// write/read strobes from the codec LR clock, with fast (skip) or slow (hold) playback.
module rec_play_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              record_btn,
    input  logic              lrc,
    input  logic [3:0]        speed,
    input  logic              speed_mode,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_stb,
    output logic              rd_stb,
    output logic              record_en,
    output logic              play_en,
    output logic [ADDR_W:0]   rec_len,
    output logic              mem_full,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RECORD     = 3'd1,
        S_REC_PAUSE  = 3'd2,
        S_PLAY       = 3'd3,
        S_PLAY_PAUSE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t                state_q, state_d, cur_state;
    logic [ADDR_W-1:0]     addr_q, addr_d, next_addr_q, next_addr_d;
    logic [ADDR_W:0]       rec_len_q, rec_len_d, nxt;
    logic                  mem_full_q, mem_full_d;
    logic                  wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
    logic                  record_en_q, play_en_q;
    logic                  step_q, step_d, done_q, done_d;
    logic [3:0]            hold_q, hold_d, hold_eff, spd_eff;
    logic [4:0]            hold_inc;
    logic                  mode_q, mode_d;
    logic                  rec_prev_q, play_prev_q;
    logic [SYNC_LEN-1:0]   sync_q;
    logic                  lrc_prev_q, tick_q;
    logic                  rec_ev, play_ev;

    // Record wins a simultaneous press; the play press is dropped.
    assign rec_ev  = record_btn & ~rec_prev_q;
    assign play_ev = play_btn & ~play_prev_q & ~rec_ev;
    assign spd_eff = (speed == 4'd0) ? 4'd1 : speed;

    // A strobe issued last cycle is followed by one "step" cycle that applies the
    // precomputed address advance (or the end-of-take return to IDLE).
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d     = state_q;
        cur_state   = state_q;
        addr_d      = addr_q;
        rec_len_d   = rec_len_q;
        mem_full_d  = mem_full_q;
        hold_d      = hold_q;
        mode_d      = mode_q;
        next_addr_d = next_addr_q;
        done_d      = done_q;
        step_d      = 1'b0;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        hold_eff    = hold_q;
        hold_inc    = 5'd0;
        nxt         = '0;

        if (step_q) begin
            if (done_q) begin
                cur_state = S_IDLE;
                state_d   = S_IDLE;
                addr_d    = '0;
            end else begin
                addr_d = next_addr_q;
            end
        end

        case (cur_state)
            S_IDLE: begin
                if (rec_ev) begin
                    state_d    = S_RECORD;
                    addr_d     = '0;
                    rec_len_d  = '0;
                    mem_full_d = 1'b0;
                end else if (play_ev && rec_len_q != '0) begin
                    state_d = S_PLAY;
                    addr_d  = '0;
                    hold_d  = 4'd0;
                end
            end
            S_RECORD: begin
                if (rec_ev) begin
                    state_d = S_IDLE;
                end else if (play_ev) begin
                    state_d = S_REC_PAUSE;
                end else if (tick_q) begin
                    wr_stb_d    = 1'b1;
                    step_d      = 1'b1;
                    rec_len_d   = {1'b0, addr_d} + (ADDR_W+1)'(1);
                    done_d      = (addr_d == ADDR_MAX);
                    next_addr_d = addr_d + ADDR_W'(1);
                    if (addr_d == ADDR_MAX) begin
                        mem_full_d = 1'b1;
                    end
                end
            end
            S_REC_PAUSE: begin
                if (rec_ev) begin
                    state_d = S_IDLE;
                end else if (play_ev) begin
                    state_d = S_RECORD;
                end
            end
            S_PLAY: begin
                if (rec_ev) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (play_ev) begin
                    state_d = S_PLAY_PAUSE;
                end else if (tick_q) begin
                    rd_stb_d = 1'b1;
                    step_d   = 1'b1;
                    mode_d   = speed_mode;
                    hold_eff = (speed_mode != mode_q) ? 4'd0 : hold_q;
                    hold_inc = {1'b0, hold_eff} + 5'd1;
                    if (!speed_mode) begin
                        nxt    = {1'b0, addr_d} + (ADDR_W+1)'(spd_eff);
                        hold_d = hold_eff;
                    end else if (hold_inc >= {1'b0, spd_eff}) begin
                        nxt    = {1'b0, addr_d} + (ADDR_W+1)'(1);
                        hold_d = 4'd0;
                    end else begin
                        nxt    = {1'b0, addr_d};
                        hold_d = hold_inc[3:0];
                    end
                    done_d      = (nxt >= rec_len_q);
                    next_addr_d = nxt[ADDR_W-1:0];
                end
            end
            S_PLAY_PAUSE: begin
                if (rec_ev) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (play_ev) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rec_len_q   <= '0;
            mem_full_q  <= 1'b0;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            record_en_q <= 1'b0;
            play_en_q   <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            next_addr_q <= '0;
            hold_q      <= 4'd0;
            mode_q      <= 1'b0;
            rec_prev_q  <= 1'b0;
            play_prev_q <= 1'b0;
            sync_q      <= '0;
            lrc_prev_q  <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            rec_len_q   <= rec_len_d;
            mem_full_q  <= mem_full_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            record_en_q <= (state_d == S_RECORD) || (state_d == S_REC_PAUSE);
            play_en_q   <= (state_d == S_PLAY) || (state_d == S_PLAY_PAUSE);
            step_q      <= step_d;
            done_q      <= done_d;
            next_addr_q <= next_addr_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            rec_prev_q  <= record_btn;
            play_prev_q <= play_btn;
            sync_q      <= {sync_q[SYNC_LEN-2:0], lrc};
            lrc_prev_q  <= sync_q[SYNC_LEN-1];
            tick_q      <= sync_q[SYNC_LEN-1] & ~lrc_prev_q;
        end
    end

    assign addr      = addr_q;
    assign wr_stb    = wr_stb_q;
    assign rd_stb    = rd_stb_q;
    assign record_en = record_en_q;
    assign play_en   = play_en_q;
    assign rec_len   = rec_len_q;
    assign mem_full  = mem_full_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Self-checking bench for rec_play_ctrl: directed scenarios plus random button/tick
// sequences, compared per operation against a transaction-level transport model.
module tb_rec_play_ctrl;

    localparam int AW   = 8;
    localparam int MAXA = (1 << AW) - 1;
    localparam int M_IDLE = 0, M_REC = 1, M_RPAUSE = 2, M_PLAY = 3, M_PPAUSE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          play_btn = 1'b0, record_btn = 1'b0, lrc = 1'b0;
    logic [3:0]    speed = 4'd1;
    logic          speed_mode = 1'b0;
    logic [AW-1:0] addr;
    logic          wr_stb, rd_stb, record_en, play_en, mem_full;
    logic [AW:0]   rec_len;
    logic [2:0]    state;

    rec_play_ctrl #(.ADDR_W(AW), .SYNC_LEN(2)) dut (
        .clk(clk), .reset(reset), .play_btn(play_btn), .record_btn(record_btn),
        .lrc(lrc), .speed(speed), .speed_mode(speed_mode), .addr(addr),
        .wr_stb(wr_stb), .rd_stb(rd_stb), .record_en(record_en), .play_en(play_en),
        .rec_len(rec_len), .mem_full(mem_full), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_wr;
        int a;
        int len;
    } strobe_t;

    strobe_t obs_q[$];
    strobe_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    int m_state = M_IDLE, m_addr = 0, m_len = 0, m_full = 0, m_hold = 0, m_mode = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_stb && rd_stb) overlap++;
            if (wr_stb) obs_q.push_back('{1'b1, int'(addr), int'(rec_len)});
            if (rd_stb) obs_q.push_back('{1'b0, int'(addr), int'(rec_len)});
        end
    end

    // Reference model: operates on whole button presses and lrc frames.
    task automatic model_rec_ev();
        case (m_state)
            M_IDLE: begin m_state = M_REC; m_addr = 0; m_len = 0; m_full = 0; end
            M_REC, M_RPAUSE: m_state = M_IDLE;
            M_PLAY, M_PPAUSE: begin m_state = M_IDLE; m_addr = 0; end
            default: ;
        endcase
    endtask

    task automatic model_play_ev();
        case (m_state)
            M_IDLE: if (m_len != 0) begin m_state = M_PLAY; m_addr = 0; m_hold = 0; end
            M_REC: m_state = M_RPAUSE;
            M_RPAUSE: m_state = M_REC;
            M_PLAY: m_state = M_PPAUSE;
            M_PPAUSE: m_state = M_PLAY;
            default: ;
        endcase
    endtask

    task automatic model_tick(input int spd_in, input int mode_in);
        int s, nxt;
        s = (spd_in == 0) ? 1 : spd_in;
        if (m_state == M_REC) begin
            exp_q.push_back('{1'b1, m_addr, m_addr + 1});
            m_len = m_addr + 1;
            if (m_addr == MAXA) begin
                m_full = 1; m_state = M_IDLE; m_addr = 0;
            end else begin
                m_addr++;
            end
        end else if (m_state == M_PLAY) begin
            exp_q.push_back('{1'b0, m_addr, m_len});
            if (mode_in != m_mode) m_hold = 0;
            m_mode = mode_in;
            if (mode_in == 0) begin
                nxt = m_addr + s;
            end else begin
                m_hold++;
                if (m_hold >= s) begin nxt = m_addr + 1; m_hold = 0; end
                else nxt = m_addr;
            end
            if (nxt >= m_len) begin m_state = M_IDLE; m_addr = 0; end
            else m_addr = nxt;
        end
    endtask

    task automatic verify(input string tag);
        check({tag, ".nstb"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            strobe_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, ".stb_wr"}, o.is_wr, e.is_wr);
            check({tag, ".stb_addr"}, o.a, e.a);
            if (e.is_wr) check({tag, ".stb_len"}, o.len, e.len);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, ".state"}, state, m_state);
        check({tag, ".addr"}, addr, m_addr);
        check({tag, ".rec_len"}, rec_len, m_len);
        check({tag, ".mem_full"}, mem_full, m_full);
        check({tag, ".record_en"}, record_en, (m_state == M_REC || m_state == M_RPAUSE));
        check({tag, ".play_en"}, play_en, (m_state == M_PLAY || m_state == M_PPAUSE));
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic press(input bit r, input bit p, input string tag);
        @(negedge clk);
        record_btn = r;
        play_btn   = p;
        @(negedge clk);
        record_btn = 1'b0;
        play_btn   = 1'b0;
        settle();
        if (r) model_rec_ev();
        else if (p) model_play_ev();
        verify(tag);
    endtask

    task automatic tick(input int s, input int m, input string tag);
        speed      = 4'(s);
        speed_mode = 1'(m);
        @(negedge clk);
        lrc = 1'b1;
        repeat (3) @(negedge clk);
        lrc = 1'b0;
        settle();
        model_tick(s, m);
        verify(tag);
    endtask

    // Play press lands in the same cycle as the lrc tick: only the transition happens.
    task automatic collide_play(input string tag);
        @(negedge clk);
        lrc = 1'b1;
        repeat (3) @(negedge clk);
        lrc      = 1'b0;
        play_btn = 1'b1;
        @(negedge clk);
        play_btn = 1'b0;
        settle();
        model_play_ev();
        verify(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset.state", state, 0);
        check("reset.addr", addr, 0);
        check("reset.rec_len", rec_len, 0);
        check("reset.strobes", {wr_stb, rd_stb, record_en, play_en, mem_full}, 0);
        reset = 1'b0;
        settle();

        // Record five samples then stop.
        press(1, 0, "t1.rec");
        for (int i = 0; i < 5; i++) tick(1, 0, "t1.tick");
        press(1, 0, "t1.stop");

        // Normal-speed playback runs off the end; sixth tick is idle.
        press(0, 1, "t2.play");
        for (int i = 0; i < 6; i++) tick(1, 0, "t2.tick");

        // Ten-sample take, fast x3 then slow x2.
        press(1, 0, "t3.rec");
        for (int i = 0; i < 10; i++) tick(5, 1, "t3.rtick");
        press(1, 0, "t3.stop");
        press(0, 1, "t3.play_fast");
        for (int i = 0; i < 5; i++) tick(3, 0, "t3.fast");
        press(0, 1, "t3.play_slow");
        for (int i = 0; i < 21; i++) tick(2, 1, "t3.slow");

        // Pause and resume, including a press colliding with a tick.
        press(0, 1, "t4.play");
        for (int i = 0; i < 3; i++) tick(1, 0, "t4.tick");
        press(0, 1, "t4.pause");
        for (int i = 0; i < 4; i++) tick(1, 0, "t4.paused");
        press(0, 1, "t4.resume");
        tick(1, 0, "t4.after");
        collide_play("t4.collide");
        tick(1, 0, "t4.paused2");
        press(0, 1, "t4.resume2");
        tick(1, 0, "t4.after2");
        press(1, 0, "t4.stop");

        // Simultaneous presses, and play with an empty take.
        press(1, 1, "t5.both");
        press(1, 0, "t5.stop");
        press(0, 1, "t5.empty_play");

        // Fill memory to the last word.
        press(1, 0, "t6.rec");
        for (int i = 0; i <= MAXA; i++) tick(0, 0, "t6.fill");
        tick(1, 0, "t6.after_full");
        press(0, 1, "t6.play");
        tick(15, 0, "t6.ptick");

        // Random operation mix.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) press(1, 0, "rnd.rec");
            else if (r < 24) press(0, 1, "rnd.play");
            else tick(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), "rnd.tick");
        end

        // Asynchronous reset in the middle of a recording.
        if (m_state != M_IDLE) press(1, 0, "t7.stop");
        if (m_state != M_IDLE) press(1, 0, "t7.stop2");
        press(1, 0, "t7.rec");
        for (int i = 0; i < 3; i++) tick(1, 0, "t7.tick");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t7.async_state", state, 0);
        check("t7.async_addr", addr, 0);
        check("t7.async_len", rec_len, 0);
        check("t7.async_flags", {wr_stb, rd_stb, record_en, play_en, mem_full}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_state = M_IDLE; m_addr = 0; m_len = 0; m_full = 0; m_hold = 0; m_mode = 0;
        obs_q.delete();
        settle();
        verify("t7.post_reset");
        press(0, 1, "t7.play_empty");

        check("no_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
